// File: rtl/exe_mdu_seq_pkg.sv
// Shared ALU control codes and multiply/divide sequencer state encodings.
package exe_mdu_seq_pkg;

  localparam int ALUCTL_WIDTH = 5;
  localparam int REG_DATA_W   = 32;

  typedef logic [ALUCTL_WIDTH-1:0] aluctl_t;
  typedef logic [REG_DATA_W-1:0]   reg_data_t;

  localparam reg_data_t ZERO_WORD = '0;

  localparam aluctl_t ALUCTL_ADD    = 5'd0;
  localparam aluctl_t ALUCTL_SUB    = 5'd1;
  localparam aluctl_t ALUCTL_AND    = 5'd2;
  localparam aluctl_t ALUCTL_OR     = 5'd3;
  localparam aluctl_t ALUCTL_XOR    = 5'd4;
  localparam aluctl_t ALUCTL_SLL    = 5'd5;
  localparam aluctl_t ALUCTL_SRL    = 5'd6;
  localparam aluctl_t ALUCTL_SRA    = 5'd7;
  localparam aluctl_t ALUCTL_SLT    = 5'd8;
  localparam aluctl_t ALUCTL_SLTU   = 5'd9;
  localparam aluctl_t ALUCTL_MUL    = 5'd10;
  localparam aluctl_t ALUCTL_MULH   = 5'd11;
  localparam aluctl_t ALUCTL_MULHSU = 5'd12;
  localparam aluctl_t ALUCTL_MULHU  = 5'd13;
  localparam aluctl_t ALUCTL_DIV    = 5'd14;
  localparam aluctl_t ALUCTL_DIVU   = 5'd15;
  localparam aluctl_t ALUCTL_REM    = 5'd16;
  localparam aluctl_t ALUCTL_REMU   = 5'd17;

  typedef enum logic [2:0] {
    MDU_IDLE      = 3'd0,
    MDU_MUL_BUSY  = 3'd1,
    MDU_DIV_BUSY  = 3'd2,
    MDU_MUL_DRAIN = 3'd3,
    MDU_DONE      = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/exe_mdu_seq_if.sv
// EX-stage <-> sequencer <-> ALU signal bundle; master is the sequencer side.
interface exe_mdu_seq_if
  import exe_mdu_seq_pkg::*;
#(
  parameter int DATA_W = 32
) ();

  logic              I_valid;
  aluctl_t           I_alu_ctrl;
  logic              I_flush;
  logic              I_ds_allowin;
  logic [DATA_W-1:0] I_alu_result;
  logic              I_mul_ready;
  logic              I_div_ready;
  logic              O_mul_start;
  logic              O_div_start;
  logic              O_signed_div;
  logic              O_annul;
  logic              O_stall_req;
  logic [DATA_W-1:0] O_result;
  logic              O_timeout;

  modport master (
    input  I_valid, I_alu_ctrl, I_flush, I_ds_allowin, I_alu_result,
           I_mul_ready, I_div_ready,
    output O_mul_start, O_div_start, O_signed_div, O_annul, O_stall_req,
           O_result, O_timeout
  );

  modport slave (
    output I_valid, I_alu_ctrl, I_flush, I_ds_allowin, I_alu_result,
           I_mul_ready, I_div_ready,
    input  O_mul_start, O_div_start, O_signed_div, O_annul, O_stall_req,
           O_result, O_timeout
  );

endinterface

// File: rtl/exe_mdu_seq_op_decode.sv
// Mul/div classification of an ALU control code; shared with the main decoder.
module mdu_op_decode
  import exe_mdu_seq_pkg::*;
(
  input  aluctl_t ctrl,
  output logic    is_mul,
  output logic    is_div,
  output logic    is_signed_div
);

  always_comb begin
    is_mul        = ctrl inside {ALUCTL_MUL, ALUCTL_MULH, ALUCTL_MULHSU, ALUCTL_MULHU};
    is_div        = ctrl inside {ALUCTL_DIV, ALUCTL_DIVU, ALUCTL_REM, ALUCTL_REMU};
    is_signed_div = ctrl inside {ALUCTL_DIV, ALUCTL_REM};
  end

endmodule

// File: rtl/exe_mdu_seq.sv
// Multi-cycle mul/div sequencer in front of the execute ALU: start pulses,
// pipeline stall, result holding, flush handling and a sticky watchdog.
module exe_mdu_seq
  import exe_mdu_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           clk,
  input  logic           rst,
  exe_mdu_seq_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  mdu_state_e        state_q, state_d;
  logic              mul_start_q, mul_start_d;
  logic              div_start_q, div_start_d;
  logic              signed_div_q, signed_div_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              is_mul, is_div, is_sdiv, op_seen, busy_d;
  logic              stall, annul;
  logic [DATA_W-1:0] res_out;

  mdu_op_decode u_dec (
    .ctrl          (bus.I_alu_ctrl),
    .is_mul        (is_mul),
    .is_div        (is_div),
    .is_signed_div (is_sdiv)
  );

  assign op_seen = bus.I_valid & (is_mul | is_div) & ~bus.I_flush;

  always_comb begin
    state_d     = state_q;
    mul_start_d = 1'b0;
    div_start_d = 1'b0;
    result_d    = result_q;
    stall       = 1'b0;
    annul       = 1'b0;
    res_out     = bus.I_alu_result;

    unique case (state_q)
      MDU_IDLE: begin
        if (op_seen) begin
          stall = 1'b1;
          if (is_mul) begin
            mul_start_d = 1'b1;
            state_d     = MDU_MUL_BUSY;
          end else begin
            div_start_d = 1'b1;
            state_d     = MDU_DIV_BUSY;
          end
        end
      end
      // Ready during the start cycle belongs to an older op and is ignored.
      MDU_MUL_BUSY: begin
        stall   = 1'b1;
        res_out = result_q;
        if (bus.I_flush) begin
          // A multiplier finishing this very cycle leaves nothing to drain.
          state_d = (bus.I_mul_ready & ~mul_start_q) ? MDU_IDLE : MDU_MUL_DRAIN;
        end else if (bus.I_mul_ready & ~mul_start_q) begin
          result_d = bus.I_alu_result;
          state_d  = MDU_DONE;
        end
      end
      MDU_DIV_BUSY: begin
        stall   = 1'b1;
        res_out = result_q;
        if (bus.I_flush) begin
          annul   = 1'b1;
          state_d = MDU_IDLE;
        end else if (bus.I_div_ready & ~div_start_q) begin
          result_d = bus.I_alu_result;
          state_d  = MDU_DONE;
        end
      end
      MDU_MUL_DRAIN: begin
        stall = op_seen;
        if (bus.I_mul_ready) state_d = MDU_IDLE;
      end
      MDU_DONE: begin
        res_out = result_q;
        if (bus.I_flush) begin
          result_d = '0;
          state_d  = MDU_IDLE;
        end else begin
          stall = ~bus.I_ds_allowin;
          if (bus.I_ds_allowin) state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase

    // Sign mode is captured at divide issue and only meaningful while busy.
    if (state_d == MDU_DIV_BUSY)
      signed_div_d = (state_q == MDU_DIV_BUSY) ? signed_div_q : is_sdiv;
    else
      signed_div_d = 1'b0;

    busy_d = (state_d == MDU_MUL_BUSY) | (state_d == MDU_DIV_BUSY) |
             (state_d == MDU_MUL_DRAIN);
    if (!busy_d)
      cnt_d = '0;
    else if (cnt_q == CNT_W'(TIMEOUT_CYC))
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;
    timeout_d = timeout_q | (cnt_d == CNT_W'(TIMEOUT_CYC));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= MDU_IDLE;
      mul_start_q  <= 1'b0;
      div_start_q  <= 1'b0;
      signed_div_q <= 1'b0;
      timeout_q    <= 1'b0;
      result_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      mul_start_q  <= mul_start_d;
      div_start_q  <= div_start_d;
      signed_div_q <= signed_div_d;
      timeout_q    <= timeout_d;
      result_q     <= result_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.O_mul_start  = mul_start_q;
  assign bus.O_div_start  = div_start_q;
  assign bus.O_signed_div = signed_div_q;
  assign bus.O_annul      = annul & rst;
  assign bus.O_stall_req  = stall;
  assign bus.O_result     = res_out;
  assign bus.O_timeout    = timeout_q;

endmodule

// File: tb/tb_exe_mdu_seq.sv
// Directed bench for exe_mdu_seq: stimulus pushes expected retire values,
// a negedge monitor pops and compares whenever EX output is accepted.
module tb_exe_mdu_seq;
  import exe_mdu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exe_mdu_seq_if #(.DATA_W(32)) bus ();

  exe_mdu_seq #(.DATA_W(32), .TIMEOUT_CYC(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0, failures = 0;
  int mul_pulses = 0, div_pulses = 0, annul_pulses = 0;
  logic [31:0] exp_q[$];

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(aluctl_t c, logic [31:0] r);
    bus.I_alu_ctrl   = c;
    bus.I_alu_result = r;
  endtask

  // Monitor: retire whenever EX holds a valid, unflushed, unstalled op taken downstream.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.O_mul_start) mul_pulses++;
        if (bus.O_div_start) div_pulses++;
        if (bus.O_annul)     annul_pulses++;
        if (bus.I_valid && !bus.O_stall_req && bus.I_ds_allowin && !bus.I_flush) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL retire_unexpected actual=%h required=none at %0t", bus.O_result, $time);
          end else begin
            e = exp_q.pop_front();
            chk32("retire_result", bus.O_result, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    bus.I_valid = 0; bus.I_alu_ctrl = ALUCTL_ADD; bus.I_flush = 0;
    bus.I_ds_allowin = 1; bus.I_alu_result = 0;
    bus.I_mul_ready = 0; bus.I_div_ready = 0;

    // Reset state
    repeat (2) tick();
    #2;
    chk1("rst_mul_start", bus.O_mul_start, 0);
    chk1("rst_div_start", bus.O_div_start, 0);
    chk1("rst_signed", bus.O_signed_div, 0);
    chk1("rst_annul", bus.O_annul, 0);
    chk1("rst_stall", bus.O_stall_req, 0);
    chk1("rst_timeout", bus.O_timeout, 0);
    chk32("rst_result", bus.O_result, 0);
    rst = 1;

    // ADD 5+7: pass-through, no stall
    tick(); setop(ALUCTL_ADD, 32'd12); bus.I_valid = 1; exp_q.push_back(32'd12);
    #2; chk1("add_stall", bus.O_stall_req, 0); chk32("add_result", bus.O_result, 32'd12);
    tick(); bus.I_valid = 0;
    #2; chk1("add_no_mul_start", bus.O_mul_start, 0); chk1("add_no_div_start", bus.O_div_start, 0);

    // MUL 3*4, ready 6 cycles after start, one cycle of downstream backpressure
    tick(); setop(ALUCTL_MUL, 32'd0); bus.I_valid = 1; exp_q.push_back(32'd12);
    #2; chk1("mul_seen_stall", bus.O_stall_req, 1); chk1("mul_seen_nostart", bus.O_mul_start, 0);
    tick(); #2; chk1("mul_start", bus.O_mul_start, 1); chk1("mul_start_stall", bus.O_stall_req, 1);
    for (int i = 1; i <= 5; i++) begin
      tick(); #2;
      chk1("mul_pulse_once", bus.O_mul_start, 0); chk1("mul_busy_stall", bus.O_stall_req, 1);
    end
    tick(); bus.I_mul_ready = 1; bus.I_alu_result = 32'd12;
    #2; chk1("mul_ready_stall", bus.O_stall_req, 1);
    tick(); bus.I_mul_ready = 0; bus.I_alu_result = 32'd99; bus.I_ds_allowin = 0;
    #2; chk32("mul_done_held", bus.O_result, 32'd12); chk1("mul_done_bp_stall", bus.O_stall_req, 1);
    tick(); bus.I_ds_allowin = 1;
    #2; chk32("mul_done_result", bus.O_result, 32'd12); chk1("mul_done_stall", bus.O_stall_req, 0);
    tick(); bus.I_valid = 0;
    #2; chk1("mul_back_idle", bus.O_stall_req, 0);

    // DIV -7/2 signed, stale ready in the start cycle, real ready at +33
    tick(); setop(ALUCTL_DIV, 32'd0); bus.I_valid = 1; exp_q.push_back(32'hFFFF_FFFD);
    #2; chk1("div_seen_stall", bus.O_stall_req, 1);
    tick(); bus.I_div_ready = 1;
    #2; chk1("div_start", bus.O_div_start, 1); chk1("div_signed", bus.O_signed_div, 1);
    tick(); bus.I_div_ready = 0;
    #2; chk1("div_early_rdy_ignored", bus.O_stall_req, 1); chk1("div_pulse_once", bus.O_div_start, 0);
    repeat (32) tick();
    bus.I_div_ready = 1; bus.I_alu_result = 32'hFFFF_FFFD;
    #2; chk1("div_signed_busy", bus.O_signed_div, 1); chk1("div_busy_stall", bus.O_stall_req, 1);
    tick(); bus.I_div_ready = 0; bus.I_alu_result = 32'd0;
    #2; chk32("div_result", bus.O_result, 32'hFFFF_FFFD);
    chk1("div_done_stall", bus.O_stall_req, 0); chk1("div_signed_cleared", bus.O_signed_div, 0);
    tick(); bus.I_valid = 0;

    // Flush 5 cycles into DIV_BUSY
    tick(); setop(ALUCTL_REM, 32'd0); bus.I_valid = 1;
    tick(); #2; chk1("rem_start", bus.O_div_start, 1);
    repeat (5) tick();
    bus.I_flush = 1;
    #2; chk1("flush_annul", bus.O_annul, 1);
    tick(); bus.I_flush = 0; bus.I_valid = 0;
    #2; chk1("annul_one_cycle", bus.O_annul, 0); chk1("flush_idle_stall", bus.O_stall_req, 0);
    tick(); bus.I_div_ready = 1; bus.I_alu_result = 32'd33;
    #2; chk1("late_rdy_no_stall", bus.O_stall_req, 0);
    tick(); bus.I_div_ready = 0; setop(ALUCTL_ADD, 32'd9); bus.I_valid = 1; exp_q.push_back(32'd9);
    #2; chk32("after_flush_passthru", bus.O_result, 32'd9);
    tick(); bus.I_valid = 0;

    // Flush during MUL_BUSY, ADD passes in drain, DIVU waits for IDLE
    tick(); setop(ALUCTL_MULHU, 32'd0); bus.I_valid = 1;
    tick(); #2; chk1("mulhu_start", bus.O_mul_start, 1);
    tick();
    tick(); bus.I_flush = 1;
    #2; chk1("mul_flush_stall", bus.O_stall_req, 1);
    tick(); bus.I_flush = 0; setop(ALUCTL_ADD, 32'd7); exp_q.push_back(32'd7);
    #2; chk1("drain_add_nostall", bus.O_stall_req, 0); chk32("drain_add_result", bus.O_result, 32'd7);
    tick(); setop(ALUCTL_DIVU, 32'd0); exp_q.push_back(32'h55);
    #2; chk1("drain_div_stall", bus.O_stall_req, 1);
    repeat (3) begin
      tick(); #2;
      chk1("drain_no_div_start", bus.O_div_start, 0); chk1("drain_div_stall", bus.O_stall_req, 1);
    end
    tick(); bus.I_mul_ready = 1;
    #2; chk1("drain_rdy_no_start", bus.O_div_start, 0); chk1("drain_rdy_stall", bus.O_stall_req, 1);
    tick(); bus.I_mul_ready = 0;
    #2; chk1("idle_divu_no_start", bus.O_div_start, 0); chk1("idle_divu_stall", bus.O_stall_req, 1);
    tick(); #2; chk1("divu_start", bus.O_div_start, 1); chk1("divu_unsigned", bus.O_signed_div, 0);
    tick(); bus.I_div_ready = 1; bus.I_alu_result = 32'h55;
    tick(); bus.I_div_ready = 0; bus.I_alu_result = 32'd0;
    #2; chk32("divu_result", bus.O_result, 32'h55);
    tick(); bus.I_valid = 0;

    // Watchdog: ready withheld, flag visible in busy cycle 64, sticky; reset clears
    tick(); setop(ALUCTL_MUL, 32'd0); bus.I_valid = 1;
    tick(); #2; chk1("wd_start", bus.O_mul_start, 1); chk1("wd_cycle1", bus.O_timeout, 0);
    repeat (62) tick();
    #2; chk1("wd_cycle63", bus.O_timeout, 0);
    tick(); #2; chk1("wd_cycle64", bus.O_timeout, 1);
    repeat (4) tick();
    #2; chk1("wd_sticky", bus.O_timeout, 1); chk1("wd_still_stall", bus.O_stall_req, 1);
    rst = 0; bus.I_valid = 0;
    tick(); #2;
    chk1("rst2_timeout", bus.O_timeout, 0);
    chk1("rst2_stall", bus.O_stall_req, 0);
    chk1("rst2_annul", bus.O_annul, 0);
    chk1("rst2_mul_start", bus.O_mul_start, 0);
    chk32("rst2_result", bus.O_result, 0);
    rst = 1;
    tick(); tick();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    chk32("mul_pulse_total", mul_pulses, 3);
    chk32("div_pulse_total", div_pulses, 3);
    chk32("annul_pulse_total", annul_pulses, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
